// File: rtl/jtframe_romarb_pkg.sv
// Shared types and helpers for the ROM request arbiter.
// Optional watchdog is enabled by defining JTFRAME_ROMARB_WDOG_EN.
package jtframe_romarb_pkg;

    localparam int ROMARB_AW   = 22;
    localparam int ROMARB_MAXS = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } romarb_st_t;

    // One-hot of the first active request found searching circularly from last+1.
    // Walking k downwards lets the nearest candidate overwrite farther ones.
    function automatic logic [ROMARB_MAXS-1:0] rr_onehot(
        input logic [ROMARB_MAXS-1:0] req,
        input logic [2:0]             last,
        input int                     slots
    );
        logic [ROMARB_MAXS-1:0] oh;
        int idx;
        oh = '0;
        for (int k = slots; k >= 1; k--) begin
            idx = (int'(last) + k) % slots;
            if (req[idx]) oh = ROMARB_MAXS'(1) << idx;
        end
        return oh;
    endfunction

endpackage

// File: rtl/jtframe_romarb_rr.sv
// Combinational round-robin picker: next grant (one-hot and index) after slot `last`.
// Part of jtframe_romrq_arb; optional watchdog macro JTFRAME_ROMARB_WDOG_EN lives in the top.
module jtframe_romarb_rr
    import jtframe_romarb_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int IW    = $clog2(SLOTS)
)(
    input  logic [SLOTS-1:0] slot_req,
    input  logic [IW-1:0]    last,
    output logic [SLOTS-1:0] grant_nx,
    output logic [IW-1:0]    idx_nx
);

    logic [ROMARB_MAXS-1:0] oh;
    logic [2:0]             idx8;

    always_comb begin
        oh   = rr_onehot(ROMARB_MAXS'(slot_req), 3'(last), SLOTS);
        idx8 = '0;
        for (int i = 0; i < ROMARB_MAXS; i++)
            if (oh[i]) idx8 = 3'(i);
    end

    assign grant_nx = oh[SLOTS-1:0];
    assign idx_nx   = IW'(idx8);

endmodule

// File: rtl/jtframe_romrq_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS ROM request slots.
// Define JTFRAME_ROMARB_WDOG_EN to add a watchdog that abandons stuck transactions.
module jtframe_romrq_arb
    import jtframe_romarb_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int WDOG  = 255
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SLOTS-1:0]           slot_req,
    input  logic [SLOTS*ROMARB_AW-1:0] slot_addr,
    output logic [SLOTS-1:0]           slot_we,
    output logic [SLOTS-1:0]           slot_din_ok,
    output logic                       sdram_req,
    output logic [ROMARB_AW-1:0]       sdram_addr,
    input  logic                       sdram_ack,
    input  logic                       sdram_rdy,
    output logic                       wdog_err
);

    localparam int IW = $clog2(SLOTS);
    localparam int WW = ($clog2(WDOG + 1) < 8) ? 8 : $clog2(WDOG + 1);

    romarb_st_t       st, st_nx;
    logic [SLOTS-1:0] grant, grant_nx;
    logic [IW-1:0]    last, idx_nx;
    logic             wd_trip;

    jtframe_romarb_rr #(.SLOTS(SLOTS), .IW(IW)) u_rr (
        .slot_req (slot_req),
        .last     (last),
        .grant_nx (grant_nx),
        .idx_nx   (idx_nx)
    );

`ifdef JTFRAME_ROMARB_WDOG_EN
    logic [WW-1:0] wd_cnt;
`endif

    always_comb begin
        st_nx   = st;
        wd_trip = 1'b0;
        case (st)
            IDLE:      if (|slot_req) st_nx = WAIT_ACK;
            WAIT_ACK:  if (sdram_ack) st_nx = WAIT_DATA;
            WAIT_DATA: if (sdram_rdy) st_nx = IDLE;
            default:   st_nx = IDLE;
        endcase
`ifdef JTFRAME_ROMARB_WDOG_EN
        // Trip on the edge where the counter would reach WDOG; a real completion wins.
        if (st != IDLE && st_nx == st && wd_cnt == WW'(WDOG - 1)) begin
            st_nx   = IDLE;
            wd_trip = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            grant      <= '0;
            last       <= IW'(SLOTS - 1);
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            st <= st_nx;
            if (st == IDLE && st_nx == WAIT_ACK) begin
                grant      <= grant_nx;
                last       <= idx_nx;
                sdram_addr <= slot_addr[idx_nx*ROMARB_AW +: ROMARB_AW];
                sdram_req  <= 1'b1;
            end
            if (st == WAIT_ACK && st_nx == WAIT_DATA) sdram_req <= 1'b0;
            if (st != IDLE && st_nx == IDLE) begin
                grant     <= '0;
                sdram_req <= 1'b0;
            end
        end
    end

`ifdef JTFRAME_ROMARB_WDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt   <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (st_nx != st)     wd_cnt <= '0;
            else if (st != IDLE) wd_cnt <= wd_cnt + 1'b1;
            if (wd_trip) wdog_err <= 1'b1;
        end
    end
`else
    assign wdog_err = 1'b0;
`endif

    // Data is broadcast; ownership and strobe are qualified per slot.
    assign slot_we     = (st == WAIT_DATA) ? grant : '0;
    assign slot_din_ok = slot_we & {SLOTS{sdram_rdy}};

endmodule
